// File: rtl/cog_pwm_meas.sv
// cog_pwm_meas: per-cog pulse/period measurement unit.
// Samples one selectable pin, and measures the period (rise to rise) and the
// high time (rise to fall) in clk_cog cycles. Results are held in capture
// registers and handed to the cog through a valid/ack handshake.
module cog_pwm_meas #(
  parameter int CNT_W = 32,
  parameter int SYNC  = 2
) (
  input  logic             clk_cog,
  input  logic             res,
  input  logic             setcfg,
  input  logic [31:0]      data,
  input  logic [31:0]      pin_in,
  input  logic             rdack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             valid,
  output logic             lost,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [4:0]       cfg_pin;
  logic             cfg_inv;
  logic [SYNC-1:0]  sync_q;
  logic             s, s_d, rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, lost_d, ovf_d;
  logic             unused_data_bits;

  // Bits [31:7] of the config word carry no meaning here.
  assign unused_data_bits = ^data[31:7];

  // Configuration register: pin select and polarity, loaded by setcfg.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      cfg_pin <= '0;
      cfg_inv <= 1'b0;
    end else if (setcfg) begin
      cfg_pin <= data[4:0];
      cfg_inv <= data[5];
    end
  end

  // Synchronizer chain for the selected pin, followed by the edge register.
  // The chain is deliberately not flushed on setcfg.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], pin_in[cfg_pin]};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC-1] ^ cfg_inv;
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign busy = (state_q == HIGH) || (state_q == LOW);

  // Measurement FSM and capture/handshake next-state logic; setcfg overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcap_d   = hcap_q;
    period_d = period;
    high_d   = high;
    valid_d  = valid;
    lost_d   = lost;
    ovf_d    = ovf;

    if (rdack) valid_d = 1'b0;

    unique case (state_q)
      IDLE: ;
      ARM: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == '1) begin
          ovf_d   = 1'b1;
          cnt_d   = '0;
          state_d = ARM;
        end else if (fall) begin
          hcap_d  = cnt_q;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == '1) begin
          ovf_d   = 1'b1;
          cnt_d   = '0;
          state_d = ARM;
        end else if (rise) begin
          period_d = cnt_q;
          high_d   = hcap_q;
          if (valid && !rdack) lost_d = 1'b1;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
          state_d  = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (setcfg) begin
      cnt_d   = '0;
      hcap_d  = '0;
      valid_d = 1'b0;
      lost_d  = 1'b0;
      ovf_d   = 1'b0;
      state_d = data[6] ? ARM : IDLE;
    end
  end

  // State, counter and capture registers.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcap_q  <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      lost    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcap_q  <= hcap_d;
      period  <= period_d;
      high    <= high_d;
      valid   <= valid_d;
      lost    <= lost_d;
      ovf     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cog_pwm_meas.sv
// Testbench for cog_pwm_meas: pin waveforms are described as per-cycle level
// lists; expected captures come from the rise/fall times of that list.
module tb_cog_pwm_meas;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  logic             clk_cog = 1'b0;
  logic             res, setcfg, rdack;
  logic [31:0]      data, pin_in;
  logic [CNT_W-1:0] period, high;
  logic             valid, lost, ovf, busy;

  int n_pass = 0;
  int n_chk  = 0;

  bit lv[$];
  bit snap_v[$], snap_l[$], snap_o[$], snap_b[$];
  int snap_p[$], snap_h[$];
  int obs_p[$], obs_h[$], obs_t[$];
  int exp_p[$], exp_h[$], exp_t[$];

  always #5 clk_cog = ~clk_cog;

  cog_pwm_meas #(.CNT_W(CNT_W), .SYNC(SYNC)) dut (
    .clk_cog(clk_cog), .res(res), .setcfg(setcfg), .data(data),
    .pin_in(pin_in), .rdack(rdack), .period(period), .high(high),
    .valid(valid), .lost(lost), .ovf(ovf), .busy(busy)
  );

  task automatic add(input bit lvl, input int n);
    for (int i = 0; i < n; i++) lv.push_back(lvl);
  endtask

  task automatic add_blocks(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      add(1'b1, h);
      add(1'b0, l);
    end
  endtask

  // Reference model: every rise after the arming one yields (rise-to-rise,
  // rise-to-fall), visible LAT cycles after the pin change that caused it.
  function automatic void build_expect(input bit inv, input int from, input bit idle);
    bit prev, s, armed;
    int last_r, last_f;
    exp_p.delete(); exp_h.delete(); exp_t.delete();
    prev = ((from == 0) ? idle : lv[from-1]) ^ inv;
    armed = 1'b0; last_r = 0; last_f = 0;
    for (int i = from; i < lv.size(); i++) begin
      s = lv[i] ^ inv;
      if (s && !prev) begin
        if (armed) begin
          exp_p.push_back(i - last_r);
          exp_h.push_back(last_f - last_r);
          exp_t.push_back(i + LAT);
        end
        armed = 1'b1;
        last_r = i;
      end
      if (!s && prev) last_f = i;
      prev = s;
    end
  endfunction

  task automatic idle(input bit lvl, input int n);
    repeat (n) begin
      @(negedge clk_cog);
      pin_in = {32{lvl}};
    end
  endtask

  task automatic cfg_load(input logic [31:0] d);
    @(negedge clk_cog);
    setcfg = 1'b1;
    data   = d;
    @(negedge clk_cog);
    setcfg = 1'b0;
    data   = $urandom;
  endtask

  // Plays lv onto the selected pin (other pins random), snapshotting outputs
  // each cycle; with auto_ack every capture is recorded and acknowledged.
  task automatic run_wave(input int pin, input bit auto_ack, input int ack_at);
    snap_v.delete(); snap_l.delete(); snap_o.delete(); snap_b.delete();
    snap_p.delete(); snap_h.delete();
    obs_p.delete(); obs_h.delete(); obs_t.delete();
    for (int i = 0; i < lv.size(); i++) begin
      @(negedge clk_cog);
      snap_v.push_back(valid); snap_l.push_back(lost);
      snap_o.push_back(ovf);   snap_b.push_back(busy);
      snap_p.push_back(int'(period)); snap_h.push_back(int'(high));
      rdack = 1'b0;
      if (auto_ack && valid) begin
        rdack = 1'b1;
        obs_p.push_back(int'(period));
        obs_h.push_back(int'(high));
        obs_t.push_back(i);
      end
      if (i == ack_at) rdack = 1'b1;
      pin_in = $urandom;
      pin_in[pin] = lv[i];
    end
    @(negedge clk_cog);
    rdack = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++; if (period !== '0) $display("FAIL reset_period got %0d want 0", period); else n_pass++;
    n_chk++; if (high !== '0)   $display("FAIL reset_high got %0d want 0", high); else n_pass++;
    n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid); else n_pass++;
    n_chk++; if (lost !== 1'b0)  $display("FAIL reset_lost got %0b want 0", lost); else n_pass++;
    n_chk++; if (ovf !== 1'b0)   $display("FAIL reset_ovf got %0b want 0", ovf); else n_pass++;
    n_chk++; if (busy !== 1'b0)  $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_basic;
    idle(1'b0, 6);
    cfg_load(32'h45);
    lv.delete(); add(1'b0, 4); add_blocks(3, 5, 5);
    build_expect(1'b0, 0, 1'b0);
    run_wave(5, 1'b1, -1);
    n_chk++; if (obs_p.size() !== exp_p.size()) $display("FAIL basic_count got %0d want %0d", obs_p.size(), exp_p.size()); else n_pass++;
    for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
      n_chk++; if (obs_p[k] !== exp_p[k]) $display("FAIL basic_period[%0d] got %0d want %0d", k, obs_p[k], exp_p[k]); else n_pass++;
      n_chk++; if (obs_h[k] !== exp_h[k]) $display("FAIL basic_high[%0d] got %0d want %0d", k, obs_h[k], exp_h[k]); else n_pass++;
      n_chk++; if (obs_t[k] !== exp_t[k]) $display("FAIL basic_time[%0d] got %0d want %0d", k, obs_t[k], exp_t[k]); else n_pass++;
    end
    n_chk++; if (obs_p.size() > 0 && obs_p[0] !== 8) $display("FAIL basic_first_period got %0d want 8", obs_p[0]); else n_pass++;
    n_chk++; if (lost !== 1'b0) $display("FAIL basic_lost got %0b want 0", lost); else n_pass++;
  endtask

  task automatic test_lost;
    idle(1'b0, 6);
    cfg_load(32'h45);
    lv.delete(); add(1'b0, 4); add_blocks(3, 5, 5);
    build_expect(1'b0, 0, 1'b0);
    run_wave(5, 1'b0, exp_t[2] - 1);
    n_chk++; if (snap_v[exp_t[0]] !== 1'b1) $display("FAIL lost_first_valid got %0b want 1", snap_v[exp_t[0]]); else n_pass++;
    n_chk++; if (snap_l[exp_t[0]] !== 1'b0) $display("FAIL lost_after_first got %0b want 0", snap_l[exp_t[0]]); else n_pass++;
    n_chk++; if (snap_l[exp_t[1]-1] !== 1'b0) $display("FAIL lost_before_second got %0b want 0", snap_l[exp_t[1]-1]); else n_pass++;
    n_chk++; if (snap_l[exp_t[1]] !== 1'b1) $display("FAIL lost_after_second got %0b want 1", snap_l[exp_t[1]]); else n_pass++;
    n_chk++; if (snap_v[exp_t[2]] !== 1'b1) $display("FAIL lost_ack_same_cycle_valid got %0b want 1", snap_v[exp_t[2]]); else n_pass++;
    n_chk++; if (snap_p[exp_t[2]] !== 8) $display("FAIL lost_third_period got %0d want 8", snap_p[exp_t[2]]); else n_pass++;
    n_chk++; if (snap_h[exp_t[2]] !== 3) $display("FAIL lost_third_high got %0d want 3", snap_h[exp_t[2]]); else n_pass++;
    n_chk++; if (lost !== 1'b1) $display("FAIL lost_sticky got %0b want 1", lost); else n_pass++;
  endtask

  task automatic test_invert;
    idle(1'b1, 6);
    cfg_load(32'h65);
    lv.delete(); add(1'b1, 4); add_blocks(3, 5, 5);
    build_expect(1'b1, 0, 1'b1);
    run_wave(5, 1'b1, -1);
    n_chk++; if (obs_p.size() !== exp_p.size()) $display("FAIL invert_count got %0d want %0d", obs_p.size(), exp_p.size()); else n_pass++;
    for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
      n_chk++; if (obs_p[k] !== exp_p[k]) $display("FAIL invert_period[%0d] got %0d want %0d", k, obs_p[k], exp_p[k]); else n_pass++;
      n_chk++; if (obs_h[k] !== exp_h[k]) $display("FAIL invert_high[%0d] got %0d want %0d", k, obs_h[k], exp_h[k]); else n_pass++;
      n_chk++; if (obs_t[k] !== exp_t[k]) $display("FAIL invert_time[%0d] got %0d want %0d", k, obs_t[k], exp_t[k]); else n_pass++;
    end
    n_chk++; if (obs_h.size() > 0 && obs_h[0] !== 5) $display("FAIL invert_first_high got %0d want 5", obs_h[0]); else n_pass++;
  endtask

  task automatic test_random;
    int pin, h, l;
    for (int run = 0; run < 3; run++) begin
      pin = $urandom_range(0, 31);
      idle(1'b0, 6);
      cfg_load(32'h40 | pin);
      lv.delete(); add(1'b0, 4);
      for (int k = 0; k < 8; k++) begin
        h = (run == 0 && k == 0) ? 1 : $urandom_range(1, 9);
        l = (run == 0 && k == 0) ? 1 : $urandom_range(1, 9);
        add(1'b1, h); add(1'b0, l);
      end
      add(1'b1, 5);
      build_expect(1'b0, 0, 1'b0);
      run_wave(pin, 1'b1, -1);
      n_chk++; if (obs_p.size() !== exp_p.size()) $display("FAIL random%0d_count got %0d want %0d", run, obs_p.size(), exp_p.size()); else n_pass++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
        n_chk++; if (obs_p[k] !== exp_p[k]) $display("FAIL random%0d_period[%0d] got %0d want %0d", run, k, obs_p[k], exp_p[k]); else n_pass++;
        n_chk++; if (obs_h[k] !== exp_h[k]) $display("FAIL random%0d_high[%0d] got %0d want %0d", run, k, obs_h[k], exp_h[k]); else n_pass++;
        n_chk++; if (obs_t[k] !== exp_t[k]) $display("FAIL random%0d_time[%0d] got %0d want %0d", run, k, obs_t[k], exp_t[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_saturation;
    int pin, first_ovf, busy_cycles;
    pin = $urandom_range(0, 31);
    idle(1'b0, 6);
    cfg_load(32'h40 | pin);
    lv.delete(); add(1'b0, 4); add(1'b1, 300); add_blocks(2, 2, 3);
    // rotate the 2/2 blocks so the tail starts low: 0,0,1,1 x3, then hold high
    lv = lv[0:303];
    for (int k = 0; k < 3; k++) begin add(1'b0, 2); add(1'b1, 2); end
    add(1'b1, 3);
    build_expect(1'b0, 304, 1'b0);
    run_wave(pin, 1'b1, -1);
    first_ovf = -1; busy_cycles = 0;
    for (int i = 0; i < snap_o.size(); i++) begin
      if (snap_o[i] && first_ovf < 0) first_ovf = i;
      if (i < 304 && snap_b[i]) busy_cycles++;
    end
    n_chk++; if (first_ovf !== 4 + LAT + 255) $display("FAIL sat_ovf_time got %0d want %0d", first_ovf, 4 + LAT + 255); else n_pass++;
    n_chk++; if (busy_cycles !== 255) $display("FAIL sat_busy_cycles got %0d want 255", busy_cycles); else n_pass++;
    n_chk++; if (snap_b[4 + LAT + 255] !== 1'b0) $display("FAIL sat_state_arm got busy=%0b want 0", snap_b[4 + LAT + 255]); else n_pass++;
    n_chk++; if (snap_v[4 + LAT + 255] !== 1'b0) $display("FAIL sat_valid got %0b want 0", snap_v[4 + LAT + 255]); else n_pass++;
    n_chk++; if (obs_p.size() !== exp_p.size()) $display("FAIL sat_count got %0d want %0d", obs_p.size(), exp_p.size()); else n_pass++;
    for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
      n_chk++; if (obs_p[k] !== exp_p[k]) $display("FAIL sat_period[%0d] got %0d want %0d", k, obs_p[k], exp_p[k]); else n_pass++;
      n_chk++; if (obs_h[k] !== exp_h[k]) $display("FAIL sat_high[%0d] got %0d want %0d", k, obs_h[k], exp_h[k]); else n_pass++;
      n_chk++; if (obs_t[k] !== exp_t[k]) $display("FAIL sat_time[%0d] got %0d want %0d", k, obs_t[k], exp_t[k]); else n_pass++;
    end
    n_chk++; if (ovf !== 1'b1) $display("FAIL sat_ovf_sticky got %0b want 1", ovf); else n_pass++;
    // the next scenario continues on this pin
    lv.delete(); lv.push_back(1'b0);
    snap_p.delete(); snap_p.push_back(pin);
  endtask

  task automatic test_setcfg_mid;
    int pin;
    pin = snap_p[0];
    lv.delete();
    add(1'b1, 2); add(1'b0, 5); add(1'b1, 3); add(1'b0, 3); add(1'b1, 2); add(1'b0, 6);
    run_wave(pin, 1'b0, -1);
    n_chk++; if (busy !== 1'b1)  $display("FAIL mid_pre_busy got %0b want 1", busy); else n_pass++;
    n_chk++; if (valid !== 1'b1) $display("FAIL mid_pre_valid got %0b want 1", valid); else n_pass++;
    n_chk++; if (lost !== 1'b1)  $display("FAIL mid_pre_lost got %0b want 1", lost); else n_pass++;
    n_chk++; if (ovf !== 1'b1)   $display("FAIL mid_pre_ovf got %0b want 1", ovf); else n_pass++;
    cfg_load(32'h40 | pin);
    n_chk++; if (valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", valid); else n_pass++;
    n_chk++; if (lost !== 1'b0)  $display("FAIL mid_lost got %0b want 0", lost); else n_pass++;
    n_chk++; if (ovf !== 1'b0)   $display("FAIL mid_ovf got %0b want 0", ovf); else n_pass++;
    n_chk++; if (busy !== 1'b0)  $display("FAIL mid_busy got %0b want 0", busy); else n_pass++;
    n_chk++; if (period !== 8'd6) $display("FAIL mid_period_held got %0d want 6", period); else n_pass++;
    lv.delete();
    add(1'b0, 2); add(1'b1, 2); add(1'b0, 3); add(1'b1, 3); add(1'b0, 4); add(1'b1, 5);
    build_expect(1'b0, 0, 1'b0);
    run_wave(pin, 1'b1, -1);
    n_chk++; if (obs_p.size() !== exp_p.size()) $display("FAIL mid_fresh_count got %0d want %0d", obs_p.size(), exp_p.size()); else n_pass++;
    for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
      n_chk++; if (obs_p[k] !== exp_p[k]) $display("FAIL mid_fresh_period[%0d] got %0d want %0d", k, obs_p[k], exp_p[k]); else n_pass++;
      n_chk++; if (obs_h[k] !== exp_h[k]) $display("FAIL mid_fresh_high[%0d] got %0d want %0d", k, obs_h[k], exp_h[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int busy_cnt;
    n_chk++; if (busy !== 1'b1) $display("FAIL rmid_pre_busy got %0b want 1", busy); else n_pass++;
    res = 1'b1;
    #1;
    n_chk++; if (period !== '0) $display("FAIL rmid_period got %0d want 0", period); else n_pass++;
    n_chk++; if (high !== '0)   $display("FAIL rmid_high got %0d want 0", high); else n_pass++;
    n_chk++; if (valid !== 1'b0) $display("FAIL rmid_valid got %0b want 0", valid); else n_pass++;
    n_chk++; if (ovf !== 1'b0)   $display("FAIL rmid_ovf got %0b want 0", ovf); else n_pass++;
    n_chk++; if (busy !== 1'b0)  $display("FAIL rmid_busy got %0b want 0", busy); else n_pass++;
    @(negedge clk_cog);
    res = 1'b0;
    lv.delete(); add_blocks(2, 2, 10);
    run_wave(0, 1'b1, -1);
    busy_cnt = 0;
    foreach (snap_b[i]) if (snap_b[i]) busy_cnt++;
    n_chk++; if (obs_p.size() !== 0) $display("FAIL rmid_idle_captures got %0d want 0", obs_p.size()); else n_pass++;
    n_chk++; if (busy_cnt !== 0) $display("FAIL rmid_idle_busy got %0d want 0", busy_cnt); else n_pass++;
    cfg_load(32'h40);
    lv.delete(); add(1'b0, 2); add(1'b1, 3); add(1'b0, 2); add(1'b1, 4);
    build_expect(1'b0, 0, 1'b0);
    run_wave(0, 1'b1, -1);
    n_chk++; if (obs_p.size() !== exp_p.size()) $display("FAIL rmid_rearm_count got %0d want %0d", obs_p.size(), exp_p.size()); else n_pass++;
    for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
      n_chk++; if (obs_p[k] !== exp_p[k]) $display("FAIL rmid_rearm_period[%0d] got %0d want %0d", k, obs_p[k], exp_p[k]); else n_pass++;
      n_chk++; if (obs_h[k] !== exp_h[k]) $display("FAIL rmid_rearm_high[%0d] got %0d want %0d", k, obs_h[k], exp_h[k]); else n_pass++;
    end
  endtask

  initial begin
    res = 1'b1; setcfg = 1'b0; data = '0; pin_in = '0; rdack = 1'b0;
    repeat (3) @(negedge clk_cog);
    res = 1'b0;
    test_reset();
    test_basic();
    test_lost();
    test_invert();
    test_random();
    test_saturation();
    test_setcfg_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
